proc_chain: RTL
===============

# proc_chain

Parametrised, self-checking processing chain: a frame source counter, NUM_STAGES buffer-plus-processing stages, and a checking sink, all on a valid/ready stream. It generalises the fixed counter → socket → passthrough → socket → sink arrangement used for hardware bring-up. Stage count, depth, width, frame length and per-stage arithmetic are parameters. Sink backpressure can be injected and the block reports received and error counts, so the same block serves as a chain smoke test and a throughput test.

## Interface
- DATA_WIDTH, 16, stream word width
- SOCKET_SIZE, 5, depth of each stage FIFO (≥2)
- NUM_STAGES, 2, number of FIFO+processing stages (≥1)
- MAX_VAL, 256, words per frame; source emits 0..MAX_VAL-1
- STAGE_INC, 1, value each processing stage adds mod 2^DATA_WIDTH (0 = passthrough)
- CNT_W, $clog2(MAX_VAL+1), derived width of o_rx_count
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_dv  in  1  source enable: start frame in IDLE, pause/resume in RUN
- i_sink_ready  in  1  sink accept; 0 injects backpressure
- o_data  out  DATA_WIDTH  last word accepted by sink
- o_rx_count  out  CNT_W  words accepted by sink this frame
- o_err_count  out  16  mismatches this frame, saturates at 16'hFFFF
- o_busy  out  1  source in RUN or data in flight
- o_done  out  1  frame fully received

## Operation
- Reset (i_rst=0): every output 0, FIFOs empty, stage registers invalid, source FSM in IDLE, counters 0. Takes effect immediately, with no clock edge.
- Source FSM states are IDLE, RUN, DONE.
  - IDLE→RUN when i_dv=1. Clears value, o_rx_count, o_err_count and o_data.
  - RUN: src_valid = i_dv. The value increments on each accept (src_valid & src_ready).
  - i_dv=0 in RUN pauses the source. The value is held and no word is lost or duplicated.
  - After the MAX_VAL-th accept, go RUN→DONE.
  - DONE→IDLE when o_done=1 and i_dv=0.
- Stage k is chain_fifo(SOCKET_SIZE) followed by a processing register.
  - The processing register's out = in + STAGE_INC, mod 2^DATA_WIDTH.
  - Its upstream ready = !out_valid | downstream ready.
- Sink accepts when valid & i_sink_ready.
  - Expected word = (o_rx_count + NUM_STAGES*STAGE_INC) mod 2^DATA_WIDTH.
  - A mismatch increments o_err_count, saturating at 16'hFFFF.
  - o_rx_count increments on every accept and o_data captures the word.
- o_done = (state==DONE) & (o_rx_count==MAX_VAL).
- o_busy = (state==RUN) | any FIFO non-empty | any stage register valid.

## Timing
- All state is registered. No combinational path from i_sink_ready to the source.
- FIFO ready = !full, derived from registered occupancy.
  - When full, no push occurs, so there is never a simultaneous push+pop at full.
  - When empty there is no fall-through. A pushed word is poppable the next cycle.
  - When 0<occupancy<depth, simultaneous push and pop leave occupancy unchanged.
- Latency from source accept to the word at the sink input is 2*NUM_STAGES cycles with no stalls. Defaults give 4 cycles.
- Source valid is first high the cycle after i_dv is sampled in IDLE.
- Throughput is 1 word/cycle with i_sink_ready held high.
- Buffering when the sink stalls is NUM_STAGES*(SOCKET_SIZE+1) words. Defaults give 12.
- Values wrap modulo 2^DATA_WIDTH at every adder and at the source. The sink's expected value wraps identically.
- Reset asserted mid-frame drops all in-flight data. After deassertion the block waits in IDLE for i_dv.

## Structure
- Package chain_pkg holds:
  - typedef enum src_state_t {IDLE, RUN, DONE}
  - localparam ERR_W = 16
  - function exp_word(idx, stages, inc) for the sink check, shared with the bench
- Sub-module chain_fifo(DATA_WIDTH, DEPTH) is a valid/ready synchronous FIFO. It has its own async active-low reset and is instantiated NUM_STAGES times via generate.
- Processing register, source FSM and sink checker are inline in proc_chain.

## Test plan
- Defaults, i_dv=1, i_sink_ready=1:
  - First sink word is 2, four cycles after the first source accept.
  - At the end of the frame, o_rx_count=256, o_err_count=0, o_done=1.
- i_sink_ready=0 for 30 cycles from frame start:
  - The source accepts exactly 12 words, then src_ready=0.
  - After release the sink receives 2,3,4,… in order, with no gaps.
- i_dv low for 10 cycles mid-frame: the sequence has no gaps or duplicates, o_err_count=0, o_rx_count=256.
- i_rst pulsed low for a non-edge-aligned 3 ns mid-frame:
  - All outputs are 0 before the next edge.
  - A subsequent frame completes with o_err_count=0.
- DATA_WIDTH=8, NUM_STAGES=4, STAGE_INC=0, MAX_VAL=300:
  - Sink sees 255 followed by 0.
  - o_rx_count=300 (9-bit), o_err_count=0.
- i_sink_ready toggling every cycle: exactly one accept per high cycle, o_done after about 512 cycles, o_err_count=0.

Source files
------------

// File: rtl/chain_pkg.sv
// Shared types and helpers for the proc_chain stream test block.
package chain_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} src_state_t;

  localparam int unsigned ERR_W = 16;

  // Word the sink expects at position idx after 'stages' adders of 'inc' each.
  // Callers truncate to their stream width, so wrapping matches the datapath.
  function automatic logic [31:0] exp_word(input logic [31:0] idx, input logic [31:0] stages,
                                           input logic [31:0] inc);
    return idx + stages * inc;
  endfunction

endpackage

// File: rtl/chain_fifo.sv
// Valid/ready synchronous FIFO with registered occupancy and no fall-through.
module chain_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic                  w_push;
  logic                  w_pop;

  // Ready and valid come only from registered occupancy.
  assign o_ready = (r_occ != OCC_W'(DEPTH));
  assign o_valid = (r_occ != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  // Pointer and occupancy update.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + OCC_W'(1);
      end else if (!w_push && w_pop) begin
        r_occ <= r_occ - OCC_W'(1);
      end
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/proc_chain.sv
// Counter source -> NUM_STAGES x (FIFO + add register) -> checking sink.
module proc_chain
  import chain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SOCKET_SIZE = 5,
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned MAX_VAL     = 256,
  parameter int unsigned STAGE_INC   = 1,
  parameter int unsigned CNT_W       = $clog2(MAX_VAL + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_dv,
  input  logic                  i_sink_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_W-1:0]      o_rx_count,
  output logic [ERR_W-1:0]      o_err_count,
  output logic                  o_busy,
  output logic                  o_done
);

  src_state_t            r_state;
  src_state_t            w_state_next;
  logic [DATA_WIDTH-1:0] r_src_val;
  logic [CNT_W-1:0]      r_src_cnt;
  logic                  w_src_valid;
  logic                  w_src_ready;
  logic                  w_src_acc;
  logic                  w_last_acc;
  logic                  w_frame_start;

  logic [NUM_STAGES-1:0] w_in_valid;
  logic [NUM_STAGES-1:0] w_in_ready;
  logic [NUM_STAGES-1:0] w_mid_valid;
  logic [NUM_STAGES-1:0] w_mid_ready;
  logic [NUM_STAGES-1:0] w_out_valid;
  logic [NUM_STAGES-1:0] w_out_ready;
  logic [DATA_WIDTH-1:0] w_in_data  [NUM_STAGES];
  logic [DATA_WIDTH-1:0] w_mid_data [NUM_STAGES];
  logic [DATA_WIDTH-1:0] w_out_data [NUM_STAGES];

  logic [DATA_WIDTH-1:0] r_sink_data;
  logic [CNT_W-1:0]      r_rx_count;
  logic [ERR_W-1:0]      r_err_count;
  logic                  w_sink_acc;
  logic [DATA_WIDTH-1:0] w_exp;

  assign w_src_valid   = (r_state == RUN) & i_dv;
  assign w_src_ready   = w_in_ready[0];
  assign w_src_acc     = w_src_valid & w_src_ready;
  assign w_last_acc    = w_src_acc & (r_src_cnt == CNT_W'(MAX_VAL - 1));
  assign w_frame_start = (r_state == IDLE) & i_dv;

  // Source FSM next-state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (i_dv) w_state_next = RUN;
      RUN:     if (w_last_acc) w_state_next = DONE;
      DONE:    if (o_done && !i_dv) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Source state, value and accept counter; the count ends the frame since the value may wrap.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_src_val <= '0;
      r_src_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_frame_start) begin
        r_src_val <= '0;
        r_src_cnt <= '0;
      end else if (w_src_acc) begin
        r_src_val <= r_src_val + DATA_WIDTH'(1);
        r_src_cnt <= r_src_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    if (k == 0) begin : g_head
      assign w_in_valid[k] = w_src_valid;
      assign w_in_data[k]  = r_src_val;
    end else begin : g_link
      assign w_in_valid[k] = w_out_valid[k-1];
      assign w_in_data[k]  = w_out_data[k-1];
    end

    if (k == NUM_STAGES - 1) begin : g_tail
      assign w_out_ready[k] = i_sink_ready;
    end else begin : g_fwd
      assign w_out_ready[k] = w_in_ready[k+1];
    end

    chain_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (SOCKET_SIZE)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (w_in_valid[k]),
      .i_data  (w_in_data[k]),
      .o_ready (w_in_ready[k]),
      .o_valid (w_mid_valid[k]),
      .o_data  (w_mid_data[k]),
      .i_ready (w_mid_ready[k])
    );

    assign w_mid_ready[k] = ~r_valid | w_out_ready[k];
    assign w_out_valid[k] = r_valid;
    assign w_out_data[k]  = r_data;

    // Processing register: load in + STAGE_INC whenever the slot is free or draining.
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else if (w_mid_ready[k]) begin
        r_valid <= w_mid_valid[k];
        if (w_mid_valid[k]) begin
          r_data <= w_mid_data[k] + DATA_WIDTH'(STAGE_INC);
        end
      end
    end
  end

  assign w_sink_acc = w_out_valid[NUM_STAGES-1] & i_sink_ready;
  assign w_exp      = DATA_WIDTH'(exp_word(32'(r_rx_count), NUM_STAGES, STAGE_INC));

  // Sink checker: capture, count and compare against the expected sequence.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sink_data <= '0;
      r_rx_count  <= '0;
      r_err_count <= '0;
    end else if (w_frame_start) begin
      r_sink_data <= '0;
      r_rx_count  <= '0;
      r_err_count <= '0;
    end else if (w_sink_acc) begin
      r_sink_data <= w_out_data[NUM_STAGES-1];
      r_rx_count  <= r_rx_count + CNT_W'(1);
      if ((w_out_data[NUM_STAGES-1] != w_exp) && (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  assign o_data      = r_sink_data;
  assign o_rx_count  = r_rx_count;
  assign o_err_count = r_err_count;
  assign o_done      = (r_state == DONE) & (r_rx_count == CNT_W'(MAX_VAL));
  assign o_busy      = (r_state == RUN) | (|w_mid_valid) | (|w_out_valid);

endmodule
